// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose: 8N1 UART receiver with 16x oversampling feeding a 4-entry receive
// FIFO. It also provides sticky overrun / framing error flags and a
// registered interrupt line.
//
// Parameters:
//   CLK_HZ     clk frequency in Hz
//   BAUD       serial bit rate; DIV = CLK_HZ/(16*BAUD) must be >= 1
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-low reset
//   rx         asynchronous serial line, idle high
//   rd_en      pop request for the FIFO head
//   err_clr    clears the sticky error flags
//   irq_en     interrupt enable
//   rx_data    FIFO head byte (meaningful only while rx_valid=1)
//   rx_valid   FIFO non-empty
//   count      FIFO occupancy, 0..4
//   overrun    sticky: a byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//   busy       receiver not idle
//   irq        registered irq_en & (count != 0)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       err_clr,
   input  logic       irq_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [2:0] count,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy,
   output logic       irq
);

   localparam int DIV = CLK_HZ / (16 * BAUD);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAITHI
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        sync1;
   logic        sync2;
   logic        line;

   logic [TW-1:0] tick_cnt;
   logic        tick;
   logic [3:0]  os_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   logic        start_frame;
   logic        sample_bit;
   logic        push;
   logic        frame_set;

   logic [7:0]  mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic        pop;
   logic        do_push;
   logic        overrun_set;
   logic [2:0]  count_next;

   // Two-flop synchronizer; both flops come out of reset high so an idle
   // line never looks like a start bit right after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

   assign line = sync2;

   // Oversampling tick generator. It is restarted when a start bit is first
   // seen so the tick phase is locked to the falling edge of each frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (start_frame || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Sampling points are expressed in ticks since entering
   // the current state: the 8th tick lands mid start bit, and every 16th tick
   // after that lands mid data/stop bit.
   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      sample_bit  = 1'b0;
      push        = 1'b0;
      frame_set   = 1'b0;
      case (state)
         IDLE: begin
            if (!line) begin
               next_state  = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (tick && os_cnt == 4'd7) begin
               next_state = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && os_cnt == 4'd15) begin
               sample_bit = 1'b1;
               if (bit_idx == 3'd7) begin
                  next_state = STOP;
               end
            end
         end
         STOP: begin
            if (tick && os_cnt == 4'd15) begin
               if (line) begin
                  push       = 1'b1;
                  next_state = IDLE;
               end else begin
                  frame_set  = 1'b1;
                  next_state = WAITHI;
               end
            end
         end
         WAITHI: begin
            if (line) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Per-state tick and bit counters; both restart on every state change.
   // In DATA the 4-bit tick count wraps 15->0 right at each sample point.
   always_ff @(posedge clk) begin
      if (!reset) begin
         os_cnt  <= '0;
         bit_idx <= '0;
      end else if (state != next_state) begin
         os_cnt  <= '0;
         bit_idx <= '0;
      end else begin
         if (tick) begin
            os_cnt <= os_cnt + 1'b1;
         end
         if (sample_bit) begin
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   // Data bits arrive LSB first and are written straight into their slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shift <= '0;
      end else if (sample_bit) begin
         shift[bit_idx] <= line;
      end
   end

   // A full FIFO still accepts a byte when the head is popped in the same
   // cycle: the popped slot is exactly the one the write pointer targets.
   assign pop         = rd_en && (count != 3'd0);
   assign do_push     = push && ((count != 3'd4) || pop);
   assign overrun_set = push && (count == 3'd4) && !pop;

   always_comb begin
      count_next = count;
      case ({do_push, pop})
         2'b10:   count_next = count + 3'd1;
         2'b01:   count_next = count - 3'd1;
         default: count_next = count;
      endcase
   end

   // FIFO storage and pointers. Storage is cleared on reset so the head
   // reads as zero after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < 4; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

   // Sticky error flags; a new error in the clearing cycle takes priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
         if (frame_set) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
      end
   end

   // Interrupt is registered from the current occupancy, so it trails
   // rx_valid by one cycle in both directions.
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_en && (count != 3'd0);
      end
   end

   assign rx_data  = mem[rd_ptr];
   assign rx_valid = (count != 3'd0);
   assign busy     = (state != IDLE);

endmodule
